// File: rtl/regfile_arb_pkg.sv
// -----------------------------------------------------------------------------
// regfile_arb_pkg
//   Shared types and defaults for the regfile write arbiter and its I/O FIFO.
//   Contents:
//     REG_ADDR_W / REG_DATA_W  regfile address and data widths
//     DEF_*                    default values for the arbiter parameters
//     arb_state_t              arbiter FSM states (IDLE, DRAIN, FORCE)
//     io_wr_req_t              one queued I/O write request (register + data)
//     io_reg_in_range()        tests whether I/O may write a register
// -----------------------------------------------------------------------------
package regfile_arb_pkg;

   localparam int REG_ADDR_W     = 5;
   localparam int REG_DATA_W     = 32;

   localparam int DEF_FIFO_DEPTH = 4;
   localparam int DEF_IO_REG_LO  = 25;
   localparam int DEF_IO_REG_HI  = 29;
   localparam int DEF_MAX_WAIT   = 8;

   // IDLE : FIFO empty
   // DRAIN: FIFO holds entries, popped whenever the CPU leaves the port free
   // FORCE: one-cycle CPU stall that pops an entry regardless of the CPU
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      FORCE = 2'd2
   } arb_state_t;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] wr_reg;
      logic [REG_DATA_W-1:0] data;
   } io_wr_req_t;

   // r0 is hard-wired zero, so it is never a legal I/O target even if the
   // window were configured to include it.
   function automatic logic io_reg_in_range(input logic [REG_ADDR_W-1:0] r,
                                            input int lo,
                                            input int hi);
      return (r != '0) && (int'(r) >= lo) && (int'(r) <= hi);
   endfunction

endpackage

// File: rtl/regfile_write_arbiter_io_wr_fifo.sv
// -----------------------------------------------------------------------------
// io_wr_fifo
//   Synchronous FIFO of io_wr_req_t entries holding I/O register writes until
//   the regfile port is free. The head entry is presented combinationally
//   (show-ahead) so the arbiter can register it onto the port in the same
//   cycle it is popped.
// Ports:
//   clock        in   system clock, rising edge
//   ctrl_reset_n in   asynchronous reset, active-low (empties the FIFO)
//   push         in   write push_req (ignored when full)
//   push_req     in   entry to enqueue
//   pop          in   remove the head entry (ignored when empty)
//   head         out  current head entry (valid while !empty)
//   full         out  DEPTH entries held
//   empty        out  no entries held
//   count        out  number of entries held, 0..DEPTH
// -----------------------------------------------------------------------------
module io_wr_fifo
   import regfile_arb_pkg::*;
#(
   parameter  int DEPTH = DEF_FIFO_DEPTH,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clock,
   input  logic             ctrl_reset_n,
   input  logic             push,
   input  io_wr_req_t       push_req,
   input  logic             pop,
   output io_wr_req_t       head,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   io_wr_req_t       mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] wr_ptr_next;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_next;
   logic [CNT_W-1:0] count_reg;
   logic [CNT_W-1:0] count_next;
   logic             wr_en;
   logic             rd_en;

   assign full  = (count_reg == CNT_W'(DEPTH));
   assign empty = (count_reg == '0);
   assign count = count_reg;
   assign head  = mem[rd_ptr_reg];

   assign wr_en = push & ~full;
   assign rd_en = pop & ~empty;

   // DEPTH is a power of two, so the pointers wrap by plain overflow.
   always_comb begin
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      count_next  = count_reg + CNT_W'(wr_en) - CNT_W'(rd_en);
      if (wr_en) begin
         wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      end
      if (rd_en) begin
         rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      end
   end

   always_ff @(posedge clock or negedge ctrl_reset_n) begin
      if (!ctrl_reset_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         count_reg  <= count_next;
      end
   end

   // Storage needs no reset: an entry is only ever read after it was written.
   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem[wr_ptr_reg] <= push_req;
      end
   end

endmodule

// File: rtl/regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter
//   Merges CPU writeback (never stalled in the default build) and I/O refresh
//   writes to r[IO_REG_LO..IO_REG_HI] onto the single regfile write port.
//   I/O requests are queued in io_wr_fifo and drained in cycles where the CPU
//   does not write. All port outputs are registered.
//
//   Optional feature (compile-time macro REGFILE_ARB_STARVE_GUARD_EN):
//     adds a wait counter of CPU-write cycles spent with I/O entries pending.
//     When it reaches MAX_WAIT the FSM enters FORCE for one cycle: cpu_stall
//     is asserted, the CPU write of that cycle is ignored (the CPU holds it and
//     re-issues it next cycle) and one I/O entry is popped instead. Without
//     the macro there is no cpu_stall port and I/O may starve indefinitely.
//
// Ports:
//   clock            in   1   system clock, rising edge
//   ctrl_reset_n     in   1   asynchronous reset, active-low
//   cpu_writeEnable  in   1   CPU writeback valid this cycle
//   cpu_writeReg     in   5   CPU destination register
//   cpu_writeData    in   32  CPU writeback data
//   io_wr_valid      in   1   I/O write request valid
//   io_wr_ready      out  1   FIFO can accept (registered from the fill level)
//   io_wr_reg        in   5   I/O destination register
//   io_wr_data       in   32  I/O write data
//   ctrl_writeEnable out  1   regfile write enable
//   ctrl_writeReg    out  5   regfile write address
//   data_writeReg    out  32  regfile write data
//   io_err_range     out  1   sticky: an out-of-range I/O write was dropped
//   cpu_stall        out  1   (REGFILE_ARB_STARVE_GUARD_EN only) FORCE cycle
// -----------------------------------------------------------------------------
module regfile_write_arbiter
   import regfile_arb_pkg::*;
#(
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter int IO_REG_LO  = DEF_IO_REG_LO,
   parameter int IO_REG_HI  = DEF_IO_REG_HI,
   parameter int MAX_WAIT   = DEF_MAX_WAIT
) (
   input  logic                  clock,
   input  logic                  ctrl_reset_n,
   input  logic                  cpu_writeEnable,
   input  logic [REG_ADDR_W-1:0] cpu_writeReg,
   input  logic [REG_DATA_W-1:0] cpu_writeData,
   input  logic                  io_wr_valid,
   output logic                  io_wr_ready,
   input  logic [REG_ADDR_W-1:0] io_wr_reg,
   input  logic [REG_DATA_W-1:0] io_wr_data,
   output logic                  ctrl_writeEnable,
   output logic [REG_ADDR_W-1:0] ctrl_writeReg,
   output logic [REG_DATA_W-1:0] data_writeReg,
   output logic                  io_err_range
`ifdef REGFILE_ARB_STARVE_GUARD_EN
   ,
   output logic                  cpu_stall
`endif
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   // Elaboration-time parameter sanity checks.
   generate
      if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
         $error("FIFO_DEPTH must be a power of two and at least 2");
      end
      if (IO_REG_LO < 1 || IO_REG_HI > 31 || IO_REG_LO > IO_REG_HI) begin : g_bad_window
         $error("I/O register window must lie within r1..r31");
      end
      if (MAX_WAIT < 1) begin : g_bad_wait
         $error("MAX_WAIT must be at least 1");
      end
   endgenerate

   // ---------------------------------------------------------------- signals
   arb_state_t            state_reg;
   arb_state_t            state_next;

   logic                  ready_reg;
   logic                  ready_next;
   logic                  err_reg;
   logic                  err_next;
   logic                  we_reg;
   logic                  we_next;
   logic [REG_ADDR_W-1:0] wreg_reg;
   logic [REG_ADDR_W-1:0] wreg_next;
   logic [REG_DATA_W-1:0] wdata_reg;
   logic [REG_DATA_W-1:0] wdata_next;

   logic                  io_accept;
   logic                  io_ok;
   logic                  fifo_push;
   logic                  fifo_pop;
   logic                  force_pop;
   logic                  cpu_win;
   io_wr_req_t            push_req;
   io_wr_req_t            head;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [CNT_W-1:0]      fifo_count;
   logic [CNT_W-1:0]      count_after;

`ifdef REGFILE_ARB_STARVE_GUARD_EN
   localparam int WAIT_W = $clog2(MAX_WAIT + 1);
   logic [WAIT_W-1:0]     wait_reg;
   logic [WAIT_W-1:0]     wait_next;
`endif

   // ------------------------------------------------------------- I/O intake
   // Out-of-range requests still complete the handshake so the producer is
   // never blocked by a bad address; they are dropped and flagged instead.
   assign io_accept = io_wr_valid & ready_reg;
   assign io_ok     = io_reg_in_range(io_wr_reg, IO_REG_LO, IO_REG_HI);
   assign fifo_push = io_accept & io_ok & ~fifo_full;
   assign push_req  = '{wr_reg: io_wr_reg, data: io_wr_data};

   io_wr_fifo #(
      .DEPTH        (FIFO_DEPTH)
   ) u_io_wr_fifo (
      .clock        (clock),
      .ctrl_reset_n (ctrl_reset_n),
      .push         (fifo_push),
      .push_req     (push_req),
      .pop          (fifo_pop),
      .head         (head),
      .full         (fifo_full),
      .empty        (fifo_empty),
      .count        (fifo_count)
   );

   // ------------------------------------------------------------ port select
   // The CPU owns the port whenever it writes, except in a FORCE cycle.
   assign cpu_win     = cpu_writeEnable & ~force_pop;
   assign fifo_pop    = (force_pop | ~cpu_writeEnable) & ~fifo_empty;
   assign count_after = fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);

   // ready is registered from the post-edge fill level, so a pop in a full
   // cycle only reopens the FIFO in the following cycle.
   assign ready_next = (count_after != CNT_W'(FIFO_DEPTH));
   assign err_next   = err_reg | (io_accept & ~io_ok);

   always_comb begin
      we_next    = 1'b0;
      wreg_next  = '0;
      wdata_next = '0;
      if (cpu_win) begin
         // Writes to r0 are passed through but never enabled.
         we_next    = (cpu_writeReg != '0);
         wreg_next  = cpu_writeReg;
         wdata_next = cpu_writeData;
      end else if (fifo_pop) begin
         we_next    = 1'b1;
         wreg_next  = head.wr_reg;
         wdata_next = head.data;
      end
   end

`ifdef REGFILE_ARB_STARVE_GUARD_EN
   // Counts CPU-write cycles that kept pending I/O off the port; any pop
   // means I/O made progress and restarts the count.
   always_comb begin
      wait_next = wait_reg;
      if (fifo_pop) begin
         wait_next = '0;
      end else if (state_reg == DRAIN && cpu_writeEnable) begin
         wait_next = wait_reg + WAIT_W'(1);
      end
   end

   always_ff @(posedge clock or negedge ctrl_reset_n) begin
      if (!ctrl_reset_n) begin
         wait_reg <= '0;
      end else begin
         wait_reg <= wait_next;
      end
   end
`endif

   // -------------------------------------------------------------------- FSM
   always_ff @(posedge clock or negedge ctrl_reset_n) begin
      if (!ctrl_reset_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         IDLE: begin
            if (fifo_push) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (count_after == '0) begin
               state_next = IDLE;
            end
`ifdef REGFILE_ARB_STARVE_GUARD_EN
            else if (wait_next == WAIT_W'(MAX_WAIT)) begin
               state_next = FORCE;
            end
`endif
         end
         FORCE: begin
            state_next = (count_after == '0) ? IDLE : DRAIN;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // FORCE is only reachable with the starvation guard compiled in.
   always_comb begin
      force_pop = 1'b0;
`ifdef REGFILE_ARB_STARVE_GUARD_EN
      force_pop = (state_reg == FORCE);
`endif
   end

`ifdef REGFILE_ARB_STARVE_GUARD_EN
   assign cpu_stall = force_pop;
`endif

   // ------------------------------------------------------- output registers
   always_ff @(posedge clock or negedge ctrl_reset_n) begin
      if (!ctrl_reset_n) begin
         ready_reg <= 1'b0;
         err_reg   <= 1'b0;
         we_reg    <= 1'b0;
         wreg_reg  <= '0;
         wdata_reg <= '0;
      end else begin
         ready_reg <= ready_next;
         err_reg   <= err_next;
         we_reg    <= we_next;
         wreg_reg  <= wreg_next;
         wdata_reg <= wdata_next;
      end
   end

   assign io_wr_ready      = ready_reg;
   assign io_err_range     = err_reg;
   assign ctrl_writeEnable = we_reg;
   assign ctrl_writeReg    = wreg_reg;
   assign data_writeReg    = wdata_reg;

endmodule
